// File: rtl/cache_fill_if.sv
// Bundle of miss, memory and cache-array signals shared between the fill FSM
// and the cache/memory side that surrounds it.
interface cache_fill_if #(
  parameter int BLOCK_WORDS = 8
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  logic             miss_detected;
  logic [15:0]      miss_address;
  logic             fsm_busy;
  logic             mem_read_en;
  logic [15:0]      memory_address;
  logic             memory_data_valid;
  logic [15:0]      memory_data;
  logic             write_data_array;
  logic [OFF_W-1:0] data_word_offset;
  logic [15:0]      data_array_data;
  logic             write_tag_array;
  logic [15:0]      fill_block_base;

  // Fill controller side
  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array,
           data_word_offset, data_array_data, write_tag_array, fill_block_base
  );

  // Cache lookup / main memory / array side
  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array,
           data_word_offset, data_array_data, write_tag_array, fill_block_base
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, issues one memory read per
// cycle for the whole block, streams returned words into the data array and
// writes the tag/valid entry together with the last word.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cache_fill_if.master  bus
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] BW_C   = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BLOCK_WORDS - 1);
  // Byte offset bits inside one block (16-bit words, so one extra bit)
  localparam logic [15:0] BASE_MASK = 16'(2 * BLOCK_WORDS - 1);

  // The FSM only counts returned words, so latency is a legality check only
  if (BLOCK_WORDS < 2 || BLOCK_WORDS > 16 ||
      (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_bw
    $error("BLOCK_WORDS must be a power of two in 2..16");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_lat
    $error("MEM_LATENCY must be in 1..8");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] recv_q,  recv_d;
  logic [15:0]      base_q,  base_d;
  logic [15:0]      addr_q,  addr_d;

  logic             busy;
  logic             rd_en;
  logic [15:0]      rd_addr;
  logic             wr_data;
  logic [OFF_W-1:0] wr_off;
  logic             wr_tag;

  // State, counters, latched block base and last issued address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      recv_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and outputs; everything is forced low while rst_n is held
  // so an aborted fill can never leak a write into the arrays
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    base_d  = base_q;
    addr_d  = addr_q;
    busy    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    wr_data = 1'b0;
    wr_off  = '0;
    wr_tag  = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          // Stall covers the miss cycle itself; first request goes out now
          busy = bus.miss_detected;
          if (bus.miss_detected) begin
            base_d  = bus.miss_address & ~BASE_MASK;
            rd_en   = 1'b1;
            rd_addr = base_d;
            addr_d  = base_d;
            issue_d = CNT_W'(1);
            recv_d  = '0;
            state_d = FILL;
          end
        end
        FILL: begin
          busy = 1'b1;
          if (issue_q < BW_C) begin
            rd_en   = 1'b1;
            rd_addr = base_q + {{(15 - CNT_W){1'b0}}, issue_q, 1'b0};
            addr_d  = rd_addr;
            issue_d = issue_q + 1'b1;
          end
          if (bus.memory_data_valid && (recv_q < BW_C)) begin
            wr_data = 1'b1;
            wr_off  = recv_q[OFF_W-1:0];
            recv_d  = recv_q + 1'b1;
            if (recv_q == LAST_C) begin
              wr_tag  = 1'b1;
              issue_d = '0;
              recv_d  = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.fsm_busy         = busy;
  assign bus.mem_read_en      = rd_en;
  assign bus.memory_address   = rd_addr;
  assign bus.write_data_array = wr_data;
  assign bus.data_word_offset = wr_off;
  assign bus.data_array_data  = bus.memory_data;
  assign bus.write_tag_array  = wr_tag;
  assign bus.fill_block_base  = base_q;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: an 8-word/latency-4 instance and a 4-word/latency-1
// instance share one pipelined memory model; sel picks the active one.
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic miss = 1'b0;
  logic [15:0] maddr = 16'h0;
  logic force_vld = 1'b0;
  logic mvld = 1'b0;
  logic [15:0] mdat = 16'h0;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {logic [3:0] off; logic [15:0] dat;} wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_addr[$];
  logic [15:0] exp_tag[$];

  cache_fill_if #(.BLOCK_WORDS(8)) b8();
  cache_fill_if #(.BLOCK_WORDS(4)) b4();

  cache_fill_fsm #(.BLOCK_WORDS(8), .MEM_LATENCY(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  cache_fill_fsm #(.BLOCK_WORDS(4), .MEM_LATENCY(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  always #5 clk = ~clk;

  assign b8.miss_detected     = miss & ~sel;
  assign b8.miss_address      = maddr;
  assign b8.memory_data_valid = (mvld | force_vld) & ~sel;
  assign b8.memory_data       = mdat;
  assign b4.miss_detected     = miss & sel;
  assign b4.miss_address      = maddr;
  assign b4.memory_data_valid = (mvld | force_vld) & sel;
  assign b4.memory_data       = mdat;

  logic        obs_busy, obs_rd, obs_wr, obs_tag;
  logic [15:0] obs_addr, obs_dad, obs_base;
  logic [3:0]  obs_off;
  assign obs_busy = sel ? b4.fsm_busy         : b8.fsm_busy;
  assign obs_rd   = sel ? b4.mem_read_en      : b8.mem_read_en;
  assign obs_addr = sel ? b4.memory_address   : b8.memory_address;
  assign obs_wr   = sel ? b4.write_data_array : b8.write_data_array;
  assign obs_off  = sel ? {2'b00, b4.data_word_offset} : {1'b0, b8.data_word_offset};
  assign obs_dad  = sel ? b4.data_array_data  : b8.data_array_data;
  assign obs_tag  = sel ? b4.write_tag_array  : b8.write_tag_array;
  assign obs_base = sel ? b4.fill_block_base  : b8.fill_block_base;

  // Pipelined memory: a request seen in cycle c returns in cycle c+latency,
  // data word = 0xA000 + word index within the block
  bit        hv[8];
  bit [15:0] ha[8];
  int        lat_i;
  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = obs_rd;
    ha[0] = obs_addr;
  end
  always @(posedge clk) begin
    #1;
    lat_i = sel ? 0 : 3;
    mvld  = hv[lat_i];
    mdat  = 16'hA000 | ((ha[lat_i] >> 1) & (sel ? 16'h3 : 16'h7));
  end

  task automatic test_reset();
    rst_n = 1'b0; miss = 1'b1; maddr = 16'h1234; sel = 1'b0;
    #12;
    n_chk++;
    if ({obs_busy, obs_rd, obs_wr, obs_tag} !== 4'b0 || obs_addr !== 16'h0 ||
        obs_off !== 4'h0 || obs_base !== 16'h0 || obs_dad !== mdat)
      $display("FAIL reset_outputs: busy=%b rd=%b wr=%b tag=%b addr=%h off=%h base=%h dad=%h, want all 0 and dad=%h",
               obs_busy, obs_rd, obs_wr, obs_tag, obs_addr, obs_off, obs_base, obs_dad, mdat);
    else n_pass++;
    sel = 1'b1; #1;
    n_chk++;
    if ({obs_busy, obs_rd, obs_tag} !== 3'b0)
      $display("FAIL reset_outputs_bw4: busy=%b rd=%b tag=%b, want 0", obs_busy, obs_rd, obs_tag);
    else n_pass++;
    sel = 1'b0; miss = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_fill(input logic [15:0] a, input logic s);
    int bw, lat, nbusy, ntag;
    logic [15:0] base, ea;
    wr_t e;
    sel = s;
    bw = s ? 4 : 8;
    lat = s ? 1 : 4;
    base = a & ~16'(2 * bw - 1);
    nbusy = 0; ntag = 0;
    @(posedge clk); #1;
    miss = 1'b1; maddr = a;
    for (int k = 0; k < bw; k++) begin
      exp_addr.push_back(base + 16'(2 * k));
      exp_wr.push_back('{off: 4'(k), dat: 16'hA000 + 16'(k)});
    end
    for (int c = 0; c <= lat + bw; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_busy !== (c < lat + bw)) $display("FAIL fill_busy c=%0d: got %b want %b", c, obs_busy, c < lat + bw);
      else n_pass++;
      if (obs_busy) nbusy++;
      n_chk++;
      if (obs_rd !== (c < bw)) $display("FAIL fill_rd_en c=%0d: got %b want %b", c, obs_rd, c < bw);
      else n_pass++;
      if (obs_rd) begin
        n_chk++;
        if (exp_addr.size() == 0) $display("FAIL fill_req_extra c=%0d: got addr %h want no request", c, obs_addr);
        else begin
          ea = exp_addr.pop_front();
          if (obs_addr !== ea) $display("FAIL fill_req_addr c=%0d: got %h want %h", c, obs_addr, ea);
          else n_pass++;
        end
      end
      if (obs_wr) begin
        n_chk++;
        if (exp_wr.size() == 0) $display("FAIL fill_wr_extra c=%0d: got off %h data %h want no write", c, obs_off, obs_dad);
        else begin
          e = exp_wr.pop_front();
          if (obs_off !== e.off || obs_dad !== e.dat || c != lat + int'(e.off))
            $display("FAIL fill_wr c=%0d: got off %h data %h want off %h data %h at c=%0d",
                     c, obs_off, obs_dad, e.off, e.dat, lat + int'(e.off));
          else n_pass++;
        end
      end
      if (obs_tag) begin
        ntag++;
        n_chk++;
        if (c != lat + bw - 1 || obs_base !== base)
          $display("FAIL fill_tag: got c=%0d base %h want c=%0d base %h", c, obs_base, lat + bw - 1, base);
        else n_pass++;
      end
      @(posedge clk); #1;
      miss = 1'b0;
      if (c == lat + bw - 1) force_vld = 1'b1;
    end
    force_vld = 1'b0;
    n_chk++;
    if (exp_addr.size() != 0 || exp_wr.size() != 0 || ntag != 1 || nbusy != lat + bw)
      $display("FAIL fill_totals: got left_req=%0d left_wr=%0d tags=%0d busy=%0d want 0 0 1 %0d",
               exp_addr.size(), exp_wr.size(), ntag, nbusy, lat + bw);
    else n_pass++;
    exp_addr.delete(); exp_wr.delete();
  endtask

  task automatic test_held_change();
    logic [15:0] ea;
    wr_t e;
    int ntag;
    ntag = 0;
    sel = 1'b0;
    @(posedge clk); #1;
    miss = 1'b1; maddr = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      exp_addr.push_back(16'h1230 + 16'(2 * k));
      exp_wr.push_back('{off: 4'(k), dat: 16'hA000 + 16'(k)});
    end
    exp_tag.push_back(16'h1230);
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_busy !== (c < 24)) $display("FAIL held_busy c=%0d: got %b want %b", c, obs_busy, c < 24);
      else n_pass++;
      if (obs_rd) begin
        n_chk++;
        if (exp_addr.size() == 0) $display("FAIL held_req_extra c=%0d: got addr %h want no request", c, obs_addr);
        else begin
          ea = exp_addr.pop_front();
          if (obs_addr !== ea || !(c < 8 || (c >= 12 && c < 20)))
            $display("FAIL held_req c=%0d: got %h want %h in cycles 0-7/12-19", c, obs_addr, ea);
          else n_pass++;
        end
      end
      if (obs_wr) begin
        n_chk++;
        if (exp_wr.size() == 0) $display("FAIL held_wr_extra c=%0d: got off %h want no write", c, obs_off);
        else begin
          e = exp_wr.pop_front();
          if (obs_off !== e.off || obs_dad !== e.dat)
            $display("FAIL held_wr c=%0d: got off %h data %h want off %h data %h", c, obs_off, obs_dad, e.off, e.dat);
          else n_pass++;
        end
      end
      if (obs_tag) begin
        ntag++;
        n_chk++;
        if (exp_tag.size() == 0) $display("FAIL held_tag_extra c=%0d: got base %h want no tag", c, obs_base);
        else begin
          ea = exp_tag.pop_front();
          if (obs_base !== ea || (c != 11 && c != 23))
            $display("FAIL held_tag c=%0d: got base %h want %h at c=11/23", c, obs_base, ea);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
      if (c == 2) begin
        maddr = 16'h4000;
        for (int k = 0; k < 8; k++) begin
          exp_addr.push_back(16'h4000 + 16'(2 * k));
          exp_wr.push_back('{off: 4'(k), dat: 16'hA000 + 16'(k)});
        end
        exp_tag.push_back(16'h4000);
      end
      if (c == 12) miss = 1'b0;
    end
    n_chk++;
    if (exp_addr.size() != 0 || exp_wr.size() != 0 || exp_tag.size() != 0 || ntag != 2)
      $display("FAIL held_totals: got left_req=%0d left_wr=%0d left_tag=%0d tags=%0d want 0 0 0 2",
               exp_addr.size(), exp_wr.size(), exp_tag.size(), ntag);
    else n_pass++;
    exp_addr.delete(); exp_wr.delete(); exp_tag.delete();
  endtask

  task automatic test_spurious_valid();
    sel = 1'b0;
    @(posedge clk); #1;
    force_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({obs_busy, obs_wr, obs_tag} !== 3'b0)
        $display("FAIL idle_valid c=%0d: got busy=%b wr=%b tag=%b want 0", c, obs_busy, obs_wr, obs_tag);
      else n_pass++;
    end
    @(posedge clk); #1;
    force_vld = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    sel = 1'b0;
    @(posedge clk); #1;
    miss = 1'b1; maddr = 16'h2222;
    @(posedge clk); #1;
    miss = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    n_chk++;
    if ({obs_busy, obs_rd, obs_wr, obs_tag} !== 4'b0 || obs_addr !== 16'h0 ||
        obs_off !== 4'h0 || obs_base !== 16'h0)
      $display("FAIL midfill_reset: busy=%b rd=%b wr=%b tag=%b addr=%h off=%h base=%h want all 0",
               obs_busy, obs_rd, obs_wr, obs_tag, obs_addr, obs_off, obs_base);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if ({obs_busy, obs_wr, obs_tag} !== 3'b0) begin
        bad++;
        $display("FAIL after_reset c=%0d: got busy=%b wr=%b tag=%b want 0", c, obs_busy, obs_wr, obs_tag);
      end else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill(16'h1234, 1'b0);
    test_held_change();
    test_spurious_valid();
    test_reset_mid_fill();
    test_fill(16'hFFF5, 1'b0);
    test_fill(16'h0ABC, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
